// File: rtl/fft_bf_sequencer.sv
// Radix-2 DIF FFT butterfly sequencer: walks stages and butterflies, issues
// operand addresses and twiddle indices over a valid/ready handshake, waits
// BF_LAT cycles between stages, then pulses done.
// Optional bit-reversed readout phase enabled by defining FFT_BITREV_EN.
module fft_bf_sequencer #(
  parameter int unsigned N_LOG2 = 4,
  parameter int unsigned BF_LAT = 2,
  localparam int unsigned SW = (N_LOG2 > 2) ? $clog2(N_LOG2) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-1:0] tw_index,
  output logic [SW-1:0]     stage
`ifdef FFT_BITREV_EN
  ,
  output logic              br_valid,
  input  logic              br_ready,
  output logic [N_LOG2-1:0] br_addr
`endif
);

  localparam int unsigned DW = (BF_LAT > 1) ? $clog2(BF_LAT + 1) : 1;
  localparam logic [N_LOG2-1:0] KLast = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0] SLast = SW'(N_LOG2 - 1);

`ifdef FFT_BITREV_EN
  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StBitrev, StDone} state_e;
  localparam state_e StFinal = StBitrev;
`else
  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone} state_e;
  localparam state_e StFinal = StDone;
`endif

  state_e            state_q;
  logic [SW-1:0]     s_q;
  logic [N_LOG2-1:0] k_q;
  logic [DW-1:0]     cnt_q;
`ifdef FFT_BITREV_EN
  logic [N_LOG2-1:0] r_q;
`endif

  logic stage_last;
  assign stage_last = (s_q == SLast);

  // Sequencer FSM: stage/butterfly/drain counters and state transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
`ifdef FFT_BITREV_EN
      r_q     <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            s_q     <= '0;
            k_q     <= '0;
          end
        end
        StIssue: begin
          if (bf_ready) begin
            if (k_q == KLast) begin
              k_q <= '0;
              if (BF_LAT == 0) begin
                // No drain interval: behave as if DRAIN expired immediately
                if (!stage_last) begin
                  s_q <= s_q + 1'b1;
                end else begin
                  state_q <= StFinal;
                end
              end else begin
                cnt_q   <= DW'(BF_LAT);
                state_q <= StDrain;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (cnt_q == DW'(1)) begin
            if (!stage_last) begin
              s_q     <= s_q + 1'b1;
              state_q <= StIssue;
            end else begin
              state_q <= StFinal;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef FFT_BITREV_EN
        StBitrev: begin
          if (br_ready) begin
            if (r_q == {N_LOG2{1'b1}}) begin
              state_q <= StDone;
            end else begin
              r_q <= r_q + 1'b1;
            end
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
          s_q     <= '0;
`ifdef FFT_BITREV_EN
          r_q     <= '0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Butterfly addressing: insert a zero bit at position (N_LOG2-1-s) of k
  always_comb begin
    logic [SW-1:0]     sh;
    logic [N_LOG2-1:0] span, j, g, a;
    sh       = SLast - s_q;
    span     = N_LOG2'(1) << sh;
    j        = k_q & (span - 1'b1);
    g        = k_q >> sh;
    a        = ((g << sh) << 1) | j;
    addr_a   = '0;
    addr_b   = '0;
    tw_index = '0;
    if (state_q == StIssue) begin
      addr_a   = a;
      addr_b   = a + span;
      tw_index = j << s_q;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    bf_valid = (state_q == StIssue);
    stage    = s_q;
  end

`ifdef FFT_BITREV_EN
  // Bit-reversed readout address
  always_comb begin
    br_valid = (state_q == StBitrev);
    br_addr  = '0;
    if (state_q == StBitrev) begin
      for (int i = 0; i < int'(N_LOG2); i++) begin
        br_addr[i] = r_q[N_LOG2-1-i];
      end
    end
  end
`endif

endmodule
